// File: rtl/xc_malu_issue.sv
// xc_malu_issue: issue/sequencing controller for the multi-cycle arithmetic unit.
// Accepts one request at a time, presents decoded one-hot uop/pack-width strobes
// to the unit until it reports ready, flushes the unit, then returns the result.
module xc_malu_issue #(
    parameter int unsigned TIMEOUT = 80,
    parameter int unsigned CW      = 7
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [2:0]    req_pw,
    input  logic [31:0]   req_rs1,
    input  logic [31:0]   req_rs2,
    input  logic [31:0]   req_rs3,
    input  logic          kill,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [63:0]   rsp_result,
    output logic          rsp_err,
    output logic [CW-1:0] rsp_cycles,

    output logic [31:0]   malu_rs1,
    output logic [31:0]   malu_rs2,
    output logic [31:0]   malu_rs3,
    output logic [13:0]   malu_uop,
    output logic [4:0]    malu_pw,
    output logic          malu_valid,
    output logic          malu_flush,
    input  logic [63:0]   malu_result,
    input  logic          malu_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FLUSH,
        S_RESP
    } state_t;

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   rs1_q;
    logic [31:0]   rs2_q;
    logic [31:0]   rs3_q;
    logic [3:0]    op_q;
    logic [2:0]    pw_q;
    logic [63:0]   result_q;
    logic          err_q;
    logic          drop_q;
    logic [CW-1:0] cycles_q;

    logic          accept;
    logic          illegal;
    logic          tmo_hit;
    logic          cyc_sat;

    assign illegal = (req_op >= 4'd14) || (req_pw >= 3'd5);
    assign accept  = (state_q == S_IDLE) && req_valid && !kill;
    assign tmo_hit = (cycles_q == TMO_LAST);
    assign cyc_sat = &cycles_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill takes priority over a same-cycle unit ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = illegal ? S_RESP : S_BUSY;
            S_BUSY:  if (kill || malu_ready || tmo_hit) state_d = S_FLUSH;
            S_FLUSH: state_d = (drop_q || kill) ? S_IDLE : S_RESP;
            S_RESP:  if (kill || rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and unit-control outputs; strobes are only driven while BUSY
    always_comb begin
        req_ready  = (state_q == S_IDLE) && !kill;
        malu_valid = (state_q == S_BUSY);
        malu_flush = (state_q == S_FLUSH);
        rsp_valid  = (state_q == S_RESP);
        malu_uop   = '0;
        malu_pw    = '0;
        if (state_q == S_BUSY) begin
            for (int unsigned i = 0; i < 14; i++) begin
                malu_uop[i] = (op_q == 4'(i));
            end
            for (int unsigned j = 0; j < 5; j++) begin
                malu_pw[j] = (pw_q == 3'(j));
            end
        end
    end

    // Operand, result, error, cycle-count and drop-flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
            op_q     <= '0;
            pw_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cycles_q <= '0;
                        drop_q   <= 1'b0;
                        if (illegal) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                        end else begin
                            rs1_q <= req_rs1;
                            rs2_q <= req_rs2;
                            rs3_q <= req_rs3;
                            op_q  <= req_op;
                            pw_q  <= req_pw;
                            err_q <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    if (!cyc_sat) cycles_q <= cycles_q + CW'(1);
                    if (kill) begin
                        drop_q <= 1'b1;
                    end else if (malu_ready) begin
                        result_q <= malu_result;
                        err_q    <= 1'b0;
                    end else if (tmo_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (kill) drop_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign malu_rs1   = rs1_q;
    assign malu_rs2   = rs2_q;
    assign malu_rs3   = rs3_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign rsp_cycles = cycles_q;

endmodule

// File: tb/tb_xc_malu_issue.sv
// Directed, table-driven bench for xc_malu_issue with a few hand-written
// sequences for kill, backpressure and asynchronous reset.
module tb_xc_malu_issue;

    localparam int CW = 7;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [2:0]    req_pw;
    logic [31:0]   req_rs1;
    logic [31:0]   req_rs2;
    logic [31:0]   req_rs3;
    logic          kill;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_result;
    logic          rsp_err;
    logic [CW-1:0] rsp_cycles;
    logic [31:0]   malu_rs1;
    logic [31:0]   malu_rs2;
    logic [31:0]   malu_rs3;
    logic [13:0]   malu_uop;
    logic [4:0]    malu_pw;
    logic          malu_valid;
    logic          malu_flush;
    logic [63:0]   malu_result;
    logic          malu_ready;

    int n_checks = 0;
    int n_fail   = 0;

    xc_malu_issue #(.TIMEOUT(80), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_pw     (req_pw),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rs3    (req_rs3),
        .kill       (kill),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_cycles (rsp_cycles),
        .malu_rs1   (malu_rs1),
        .malu_rs2   (malu_rs2),
        .malu_rs3   (malu_rs3),
        .malu_uop   (malu_uop),
        .malu_pw    (malu_pw),
        .malu_valid (malu_valid),
        .malu_flush (malu_flush),
        .malu_result(malu_result),
        .malu_ready (malu_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  pw;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        int          k;        // unit ready after k BUSY cycles, 0 = never
        logic [63:0] res;      // value the unit stub drives
        logic [13:0] e_uop;
        logic [4:0]  e_pw;
        logic        e_err;
        logic [63:0] e_result;
        int          e_cyc;
        int          e_lat;    // cycles from accept to rsp_valid
        int          e_nval;   // cycles malu_valid high
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one request at a negedge; returns at the first negedge after acceptance
    task automatic issue(input logic [3:0] op, input logic [2:0] pw,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clock);
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_pw    = pw;
        req_rs1   = a;
        req_rs2   = b;
        req_rs3   = c;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input int id, input vec_t v, input bit hold);
        int lat;
        int nval;
        int nflush;
        int bad;
        issue(v.op, v.pw, v.rs1, v.rs2, v.rs3);
        lat = 1; nval = 0; nflush = 0; bad = 0;
        malu_result = v.res;
        while (!rsp_valid && lat < 200) begin
            if (malu_valid) begin
                nval++;
                if (malu_uop !== v.e_uop || malu_pw !== v.e_pw ||
                    malu_rs1 !== v.rs1 || malu_rs2 !== v.rs2 || malu_rs3 !== v.rs3) bad++;
                malu_ready = (nval == v.k);
            end else begin
                malu_ready = 1'b0;
                if (malu_uop !== '0 || malu_pw !== '0) bad++;
            end
            if (malu_flush) nflush++;
            @(negedge clock);
            lat++;
        end
        malu_ready = 1'b0;
        check($sformatf("v%0d_latency", id), lat, v.e_lat);
        check($sformatf("v%0d_valid_cycles", id), nval, v.e_nval);
        check($sformatf("v%0d_flush_cycles", id), nflush, (v.e_nval > 0) ? 1 : 0);
        check($sformatf("v%0d_strobe_errors", id), bad, 0);
        check($sformatf("v%0d_rsp_result", id), rsp_result, v.e_result);
        check($sformatf("v%0d_rsp_err", id), rsp_err, v.e_err);
        check($sformatf("v%0d_rsp_cycles", id), rsp_cycles, v.e_cyc);
        check($sformatf("v%0d_req_ready_in_resp", id), req_ready, 0);
        if (!hold) begin
            rsp_ready = 1'b1;
            @(negedge clock);
            rsp_ready = 1'b0;
            check($sformatf("v%0d_rsp_done", id), rsp_valid, 0);
            check($sformatf("v%0d_req_ready_after", id), req_ready, 1);
        end
    endtask

    initial begin
        vec_t w;
        int bad;
        logic [63:0] held_res;

        vecs[0] = '{4'd4,  3'd0, 32'd7,   32'd6, 32'd0, 3, 64'h2A,
                    14'h0010, 5'b00001, 1'b0, 64'h2A, 3, 5, 3};
        vecs[1] = '{4'd15, 3'd0, 32'd1,   32'd2, 32'd3, 1, 64'h77,
                    14'h0000, 5'b00000, 1'b1, 64'h0, 0, 1, 0};
        vecs[2] = '{4'd4,  3'd6, 32'd1,   32'd2, 32'd3, 1, 64'h77,
                    14'h0000, 5'b00000, 1'b1, 64'h0, 0, 1, 0};
        vecs[3] = '{4'd0,  3'd4, 32'd100, 32'd7, 32'd0, 1, 64'h0E,
                    14'h0001, 5'b10000, 1'b0, 64'h0E, 1, 3, 1};
        vecs[4] = '{4'd9,  3'd3, 32'hA5A5_0001, 32'h0F0F_F0F0, 32'h1, 2, 64'hDEAD_BEEF_0000_0001,
                    14'h0200, 5'b01000, 1'b0, 64'hDEAD_BEEF_0000_0001, 2, 4, 2};
        vecs[5] = '{4'd7,  3'd1, 32'h1234, 32'h5678, 32'h9ABC, 4, 64'h5555,
                    14'h0080, 5'b00010, 1'b0, 64'h5555, 4, 6, 4};
        vecs[6] = '{4'd14, 3'd2, 32'd9,   32'd9, 32'd9, 1, 64'h1,
                    14'h0000, 5'b00000, 1'b1, 64'h0, 0, 1, 0};
        vecs[7] = '{4'd3,  3'd5, 32'd9,   32'd9, 32'd9, 1, 64'h1,
                    14'h0000, 5'b00000, 1'b1, 64'h0, 0, 1, 0};
        vecs[8] = '{4'd12, 3'd2, 32'd11,  32'd22, 32'd33, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                    14'h1000, 5'b00100, 1'b1, 64'h0, 80, 82, 80};

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_pw = '0;
        req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; kill = 1'b0;
        rsp_ready = 1'b0; malu_result = '0; malu_ready = 1'b0;

        #3;
        check("reset_req_ready", req_ready, 1);
        check("reset_malu_valid", malu_valid, 0);
        check("reset_malu_flush", malu_flush, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_uop_pw", {malu_uop, malu_pw}, 0);
        #9 reset = 1'b0;

        for (int i = 0; i < 9; i++) run_txn(i, vecs[i], 1'b0);

        // kill in IDLE blocks acceptance
        @(negedge clock);
        kill = 1'b1; req_valid = 1'b1; req_op = 4'd4; req_pw = 3'd0;
        #1 check("kill_idle_req_ready", req_ready, 0);
        @(negedge clock);
        kill = 1'b0; req_valid = 1'b0;
        check("kill_idle_no_busy", malu_valid, 0);
        check("kill_idle_no_rsp", rsp_valid, 0);

        // kill in BUSY with malu_ready in the same cycle: result discarded
        issue(4'd4, 3'd0, 32'd3, 32'd5, 32'd0);
        check("killb_busy", malu_valid, 1);
        kill = 1'b1; malu_ready = 1'b1; malu_result = 64'hDEAD;
        @(negedge clock);
        kill = 1'b0; malu_ready = 1'b0;
        check("killb_flush", malu_flush, 1);
        check("killb_valid_low", malu_valid, 0);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || malu_valid !== 1'b0) bad++;
        end
        check("killb_no_rsp", bad, 0);
        check("killb_idle", req_ready, 1);
        w = '{4'd13, 3'd0, 32'd2, 32'd3, 32'd4, 2, 64'h1234_5678,
              14'h2000, 5'b00001, 1'b0, 64'h1234_5678, 2, 4, 2};
        run_txn(20, w, 1'b0);

        // Backpressure in RESP, then kill together with rsp_ready
        w = '{4'd5, 3'd0, 32'd9, 32'd11, 32'd0, 2, 64'h99,
              14'h0020, 5'b00001, 1'b0, 64'h99, 2, 4, 2};
        run_txn(21, w, 1'b1);
        held_res = rsp_result;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_result !== 64'h99 || rsp_err !== 1'b0 ||
                rsp_cycles !== 7'd2 || req_ready !== 1'b0) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_result_held", rsp_result, held_res);
        kill = 1'b1; rsp_ready = 1'b1;
        @(negedge clock);
        kill = 1'b0; rsp_ready = 1'b0;
        check("bp_kill_rsp_drop", rsp_valid, 0);
        #1 check("bp_kill_idle", req_ready, 1);

        // Asynchronous reset in the middle of BUSY
        issue(4'd6, 3'd1, 32'hCAFE, 32'hBEEF, 32'h1);
        @(negedge clock);
        check("rst_busy_before", malu_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", malu_valid, 0);
        check("rst_async_uop", malu_uop, 0);
        check("rst_async_flush", malu_flush, 0);
        check("rst_async_rs1", malu_rs1, 0);
        check("rst_async_req_ready", req_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_after_req_ready", req_ready, 1);
        check("rst_after_valid", malu_valid, 0);
        check("rst_after_flush", malu_flush, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
